// File: rtl/mips_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit that sits
// beside the execute-stage ALU.
package mips_pkg;

  // Operation codes as presented by the execute stage
  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } muldiv_op_t;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } muldiv_state_t;

  // Radix-2 divider produces one quotient bit per iteration
  localparam int DIV_ITERS = 32;

  // Two's complement negation modulo 2^32
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  // Magnitude of an operand; unsigned ops pass the value straight through
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/div_radix2_core.sv
// Restoring radix-2 divider datapath. One quotient bit per step, MSB first,
// on unsigned 32-bit operands. A zero divisor is not trapped: every trial
// subtract succeeds, giving an all-ones quotient and remainder = dividend.
module div_radix2_core
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        step,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic        q_bit;
  logic [31:0] next_rem;

  // Trial subtract of the divisor from the remainder shifted left by one dividend bit
  always_comb begin
    shifted  = {rem_q, quo_q[31]};
    diff     = {1'b0, shifted} - {2'b00, dvs_q};
    q_bit    = ~diff[33];
    next_rem = q_bit ? diff[31:0] : shifted[31:0];
  end

  // Partial remainder / quotient shift registers; the quotient register
  // doubles as the dividend shifter so both live in one 64-bit window
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= next_rem;
      quo_q <= {quo_q[30:0], q_bit};
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO unit. Accepts MULT/MULTU/DIV/DIVU from execute, runs a
// fixed-latency product pipeline or the iterative divider on operand
// magnitudes, fixes up signs in FIX and writes HI/LO. Stalls the pipeline
// when another HI/LO consumer or producer reaches execute mid-operation.
module muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_e,
  input  logic [1:0]  op_e,
  input  logic [31:0] src_a_e,
  input  logic [31:0] src_b_e,
  input  logic        hilo_read_e,
  input  logic        mthi_e,
  input  logic        mtlo_e,
  input  logic [31:0] wdata_e,
  input  logic        abort,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  muldiv_state_t state;
  muldiv_op_t    op_in;
  muldiv_op_t    op_q;
  logic [5:0]    cnt;
  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic          neg_quo;
  logic          neg_rem;
  logic          in_signed;
  logic          in_mul;
  logic          accept;
  logic          div_load;
  logic          div_step;
  logic [31:0]   div_quotient;
  logic [31:0]   div_remainder;
  logic [63:0]   prod_pipe [MUL_LATENCY];
  logic [63:0]   prod_final;

  assign op_in     = muldiv_op_t'(op_e);
  assign in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign in_mul    = (op_in == OP_MULT) || (op_in == OP_MULTU);
  assign accept    = (state == IDLE) && start_e && !abort;

  assign div_load  = accept && !in_mul;
  assign div_step  = (state == DIV) && !abort;

  assign busy  = (state != IDLE);
  assign stall = busy & (start_e | hilo_read_e | mthi_e | mtlo_e);

  assign prod_final = prod_pipe[MUL_LATENCY-1];

  div_radix2_core u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .dividend  (mag32(src_a_e, in_signed)),
    .divisor   (mag32(src_b_e, in_signed)),
    .step      (div_step),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

  // Product pipeline on the latched magnitudes; its depth matches the MUL dwell
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_LATENCY; i++) prod_pipe[i] <= '0;
    end else begin
      prod_pipe[0] <= {32'd0, mag_a} * {32'd0, mag_b};
      for (int i = 1; i < MUL_LATENCY; i++) prod_pipe[i] <= prod_pipe[i-1];
    end
  end

  // Sequencer FSM: operand capture, dwell counting, sign fix-up and HI/LO ownership
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= OP_MULT;
      cnt     <= '0;
      mag_a   <= '0;
      mag_b   <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_e) begin
              op_q    <= op_in;
              mag_a   <= mag32(src_a_e, in_signed);
              mag_b   <= mag32(src_b_e, in_signed);
              neg_quo <= in_signed & (src_a_e[31] ^ src_b_e[31]);
              neg_rem <= in_signed & src_a_e[31];
              if (in_mul) begin
                cnt   <= 6'(MUL_LATENCY - 1);
                state <= MUL;
              end else begin
                cnt   <= 6'(DIV_ITERS - 1);
                state <= DIV;
              end
            end else begin
              if (mthi_e) hi <= wdata_e;
              if (mtlo_e) lo <= wdata_e;
            end
          end
          MUL, DIV: begin
            if (cnt == 6'd0) begin
              state <= FIX;
            end else begin
              cnt <= cnt - 6'd1;
            end
          end
          FIX: begin
            if ((op_q == OP_MULT) || (op_q == OP_MULTU)) begin
              {hi, lo} <= neg_quo ? (~prod_final + 64'd1) : prod_final;
            end else begin
              lo <= neg_quo ? neg32(div_quotient) : div_quotient;
              hi <= neg_rem ? neg32(div_remainder) : div_remainder;
            end
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases followed by
// randomized operations compared against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam int MUL_LAT = 3;

  logic        clk;
  logic        rst;
  logic        start_e;
  logic [1:0]  op_e;
  logic [31:0] src_a_e;
  logic [31:0] src_b_e;
  logic        hilo_read_e;
  logic        mthi_e;
  logic        mtlo_e;
  logic [31:0] wdata_e;
  logic        abort;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;

  int tests = 0;
  int fails = 0;

  muldiv_sequencer #(.MUL_LATENCY(MUL_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_e     (start_e),
    .op_e        (op_e),
    .src_a_e     (src_a_e),
    .src_b_e     (src_b_e),
    .hilo_read_e (hilo_read_e),
    .mthi_e      (mthi_e),
    .mtlo_e      (mtlo_e),
    .wdata_e     (wdata_e),
    .abort       (abort),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .stall       (stall),
    .done        (done)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {hi,lo} from plain arithmetic on the architectural rules
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic            sgn;
    logic [31:0]     ma;
    logic [31:0]     mb;
    logic [31:0]     q;
    logic [31:0]     r;
    case (op)
      2'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      2'd1: begin
        ua = {32'd0, a};
        ub = {32'd0, b};
        return 64'(ua * ub);
      end
      default: begin
        sgn = (op == 2'd2);
        ma  = (sgn && a[31]) ? 32'(0 - a) : a;
        mb  = (sgn && b[31]) ? 32'(0 - b) : b;
        if (mb == 32'd0) begin
          q = 32'hFFFF_FFFF;
          r = ma;
        end else begin
          q = ma / mb;
          r = ma % mb;
        end
        if (sgn && (a[31] ^ b[31])) q = 32'(0 - q);
        if (sgn && a[31]) r = 32'(0 - r);
        return {r, q};
      end
    endcase
  endfunction

  function automatic int ref_busy_len(input logic [1:0] op);
    return op[1] ? 33 : MUL_LAT + 1;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a start for one cycle; returns at the first busy cycle
  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_e = 1'b1;
    op_e    = op;
    src_a_e = a;
    src_b_e = b;
    @(negedge clk);
    start_e = 1'b0;
    src_a_e = $urandom;
    src_b_e = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int cycles;
    int dones;
    exp    = ref_result(op, a, b);
    cycles = 0;
    dones  = 0;
    apply_stimulus(op, a, b);
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    check_output({tag, "_busy_len"}, 64'(cycles), 64'(ref_busy_len(op)));
    check_output({tag, "_done"}, {63'd0, done}, 64'd1);
    check_output({tag, "_hi"}, {32'd0, hi}, {32'd0, exp[63:32]});
    check_output({tag, "_lo"}, {32'd0, lo}, {32'd0, exp[31:0]});
    check_output({tag, "_early_done"}, 64'(dones), 64'd0);
    @(negedge clk);
    check_output({tag, "_done_clear"}, {63'd0, done}, 64'd0);
  endtask

  task automatic write_hilo(input logic [31:0] hv, input logic [31:0] lv);
    mthi_e  = 1'b1;
    wdata_e = hv;
    @(negedge clk);
    mthi_e  = 1'b0;
    mtlo_e  = 1'b1;
    wdata_e = lv;
    @(negedge clk);
    mtlo_e  = 1'b0;
    check_output("mt_hi", {32'd0, hi}, {32'd0, hv});
    check_output("mt_lo", {32'd0, lo}, {32'd0, lv});
    check_output("mt_no_done", {63'd0, done}, 64'd0);
  endtask

  initial begin
    logic [63:0] exp;
    logic [63:0] exp2;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int cycles;
    int dones;

    rst = 1'b1; start_e = 1'b0; op_e = 2'd0; src_a_e = '0; src_b_e = '0;
    hilo_read_e = 1'b0; mthi_e = 1'b0; mtlo_e = 1'b0; wdata_e = '0; abort = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_hi", {32'd0, hi}, 64'd0);
    check_output("rst_lo", {32'd0, lo}, 64'd0);
    check_output("rst_busy", {63'd0, busy}, 64'd0);
    check_output("rst_stall", {63'd0, stall}, 64'd0);
    check_output("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed arithmetic corners
    run_op("mult_neg3x7", 2'd0, 32'hFFFF_FFFD, 32'd7);
    check_output("mult_neg3x7_lit_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    check_output("mult_neg3x7_lit_lo", {32'd0, lo}, 64'hFFFF_FFEB);
    run_op("divu_100_7", 2'd3, 32'd100, 32'd7);
    check_output("divu_100_7_lit", {hi, lo}, {32'd2, 32'd14});
    run_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2);
    check_output("div_m7_2_lit", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check_output("div_ovf_lit", {hi, lo}, {32'd0, 32'h8000_0000});
    run_op("divu_by0", 2'd3, 32'h1234, 32'd0);
    check_output("divu_by0_lit", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});
    run_op("div_neg_by0", 2'd2, 32'hFFFF_FF00, 32'd0);
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // mfhi/mflo held in execute behind a MULTU
    ra  = $urandom;
    rb  = $urandom;
    exp = ref_result(2'd1, ra, rb);
    apply_stimulus(2'd1, ra, rb);
    hilo_read_e = 1'b1;
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      check_output("read_stall_high", {63'd0, stall}, 64'd1);
      cycles++;
      @(negedge clk);
    end
    check_output("read_stall_len", 64'(cycles), 64'(MUL_LAT + 1));
    check_output("read_stall_low", {63'd0, stall}, 64'd0);
    check_output("read_sees_lo", {32'd0, lo}, {32'd0, exp[31:0]});
    hilo_read_e = 1'b0;
    @(negedge clk);

    // Back-to-back: DIVU held behind a MULT
    exp  = ref_result(2'd0, 32'hFFFF_0003, 32'h0001_2345);
    exp2 = ref_result(2'd3, 32'hDEAD_BEEF, 32'd1000);
    apply_stimulus(2'd0, 32'hFFFF_0003, 32'h0001_2345);
    start_e = 1'b1; op_e = 2'd3; src_a_e = 32'hDEAD_BEEF; src_b_e = 32'd1000;
    cycles = 0;
    dones  = 0;
    while (busy === 1'b1 && cycles < 100) begin
      check_output("b2b_stall", {63'd0, stall}, 64'd1);
      if (done === 1'b1) dones++;
      cycles++;
      @(negedge clk);
    end
    check_output("b2b_mul_len", 64'(cycles), 64'(MUL_LAT + 1));
    check_output("b2b_mul_result", {hi, lo}, exp);
    check_output("b2b_idle_stall", {63'd0, stall}, 64'd0);
    if (done === 1'b1) dones++;
    @(negedge clk);
    start_e = 1'b0;
    cycles  = 0;
    while (busy === 1'b1 && cycles < 100) begin
      if (done === 1'b1) dones++;
      cycles++;
      @(negedge clk);
    end
    if (done === 1'b1) dones++;
    check_output("b2b_div_len", 64'(cycles), 64'd33);
    check_output("b2b_div_result", {hi, lo}, exp2);
    @(negedge clk);
    if (done === 1'b1) dones++;
    check_output("b2b_done_count", 64'(dones), 64'd2);

    // Abort mid-divide keeps HI/LO
    write_hilo(32'hAAAA, 32'h5555);
    apply_stimulus(2'd2, 32'h0012_3456, 32'd77);
    cycles = 1;
    while (cycles < 10) begin
      @(negedge clk);
      cycles++;
    end
    check_output("abort_pre_busy", {63'd0, busy}, 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("abort_busy", {63'd0, busy}, 64'd0);
    check_output("abort_hilo", {hi, lo}, {32'hAAAA, 32'h5555});
    check_output("abort_done", {63'd0, done}, 64'd0);
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check_output("abort_late_done", {63'd0, done}, 64'd0);
    check_output("abort_no_pulse", 64'(dones), 64'd2);
    check_output("abort_hilo_late", {hi, lo}, {32'hAAAA, 32'h5555});

    // Reset mid-divide zeroes HI/LO
    write_hilo(32'hAAAA, 32'h5555);
    apply_stimulus(2'd2, 32'h0012_3456, 32'd77);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("rst_mid_busy", {63'd0, busy}, 64'd0);
    check_output("rst_mid_hilo", {hi, lo}, 64'd0);
    check_output("rst_mid_done", {63'd0, done}, 64'd0);
    @(negedge clk);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      if ($urandom_range(0, 4) == 0) write_hilo($urandom, $urandom);
      run_op($sformatf("rand%0d", i), rop, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
